// File: rtl/prbs_tx_gen_pkg.sv
// prbs_pack: shared PRBS constants, FSM encoding and LFSR advance helper
package prbs_pack;
    localparam int NPRBS = 32;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} prbs_fsm_t;

    function automatic logic [NPRBS-1:0] prbs_advance(input logic [NPRBS-1:0] state,
                                                      input logic [NPRBS-1:0] eqn,
                                                      input int steps);
        logic [NPRBS-1:0] s;
        s = state;
        for (int i = 0; i < steps; i++) s = {s[NPRBS-2:0], ^(s & eqn)};
        return s;
    endfunction
endpackage

// File: rtl/prbs_tx_gen_unroll.sv
// prbs_word_unroll: combinational Nti-step Fibonacci LFSR unroll, bit 0 is the earliest step
module prbs_word_unroll
    import prbs_pack::*;
#(
    parameter int Nti   = 16,
    parameter int Nprbs = NPRBS
) (
    input  logic [Nprbs-1:0] state,
    input  logic [Nprbs-1:0] eqn,
    output logic [Nprbs-1:0] next_state,
    output logic [Nti-1:0]   word
);
    always_comb begin
        next_state = state;
        word       = '0;
        for (int i = 0; i < Nti; i++) begin
            word[i]    = ^(next_state & eqn);
            next_state = {next_state[Nprbs-2:0], word[i]};
        end
    end
endmodule

// File: rtl/prbs_tx_gen.sv
// prbs_tx_gen: parallel PRBS source with valid/ready output and periodic single-bit error injection
module prbs_tx_gen
    import prbs_pack::*;
#(
    parameter int Nti   = 16,
    parameter int Nprbs = NPRBS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [Nprbs-1:0]       prbs_eqn,
    input  logic [Nprbs-1:0]       prbs_seed,
    input  logic [31:0]            err_inj_period,
    input  logic [$clog2(Nti)-1:0] err_inj_lane,
    output logic [Nti-1:0]         data_out,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic [63:0]            words_sent,
    output logic [31:0]            errs_injected
);
    prbs_fsm_t fsm, fsm_next;
    logic [Nprbs-1:0] lfsr, lfsr_next;
    logic [Nti-1:0]   word, inj_mask;
    logic [31:0]      inj_cnt;
    logic             inj_hit, inj_flag;

    prbs_word_unroll #(.Nti(Nti), .Nprbs(Nprbs)) u_unroll (
        .state      (lfsr),
        .eqn        (prbs_eqn),
        .next_state (lfsr_next),
        .word       (word)
    );

    assign inj_hit  = (err_inj_period != 32'd0) && (inj_cnt == err_inj_period - 32'd1);
    assign inj_mask = inj_hit ? Nti'(1) << err_inj_lane : '0;

    always_comb begin
        fsm_next = (fsm == IDLE) ? (en ? LOAD : IDLE) :
                   (fsm == LOAD) ? RUN : (en ? RUN : IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_next;
    end

    // inj_flag travels with data_out so the injected count follows acceptance, not generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr          <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            inj_flag      <= 1'b0;
            inj_cnt       <= '0;
            words_sent    <= '0;
            errs_injected <= '0;
        end else begin
            if (data_valid && data_ready) begin
                words_sent <= words_sent + 64'd1;
                if (inj_flag) errs_injected <= errs_injected + 32'd1;
            end
            case (fsm)
                IDLE: inj_cnt <= '0;
                LOAD: begin
                    lfsr    <= (prbs_seed == '0) ? Nprbs'(1) : prbs_seed;
                    inj_cnt <= '0;
                end
                RUN: begin
                    if (!en) begin
                        data_valid <= 1'b0;
                        data_out   <= '0;
                        inj_flag   <= 1'b0;
                    end else if (!data_valid || data_ready) begin
                        data_out   <= word ^ inj_mask;
                        inj_flag   <= inj_hit;
                        lfsr       <= lfsr_next;
                        data_valid <= 1'b1;
                        inj_cnt    <= inj_hit ? 32'd0 : inj_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prbs_tx_gen.sv
// tb_prbs_tx_gen: randomized scoreboard bench for prbs_tx_gen against a serial bit-stream model
module tb_prbs_tx_gen;
    localparam int NTI = 16;
    localparam int NP  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            data_ready = 1'b0;
    logic [NP-1:0]   prbs_eqn = '0;
    logic [NP-1:0]   prbs_seed = '0;
    logic [31:0]     err_inj_period = '0;
    logic [3:0]      err_inj_lane = '0;
    logic [NTI-1:0]  data_out;
    logic            data_valid;
    logic [63:0]     words_sent;
    logic [31:0]     errs_injected;

    prbs_tx_gen #(.Nti(NTI), .Nprbs(NP)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .prbs_eqn       (prbs_eqn),
        .prbs_seed      (prbs_seed),
        .err_inj_period (err_inj_period),
        .err_inj_lane   (err_inj_lane),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .words_sent     (words_sent),
        .errs_injected  (errs_injected)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [NP-1:0]  m_s, m_eqn;
    int             m_period, m_lane, wi, run_acc;
    longint         exp_words = 0, exp_errs = 0;
    logic           prev_stall = 1'b0;
    logic [NTI-1:0] prev_data = '0;
    logic [31:0]    base_errs;
    logic [63:0]    base_words;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // serial reference: one bit per LFSR step, earliest bit lands in bit 0
    task automatic gen_word(output logic [NTI-1:0] w);
        logic b;
        for (int i = 0; i < NTI; i++) begin
            b    = ^(m_s & m_eqn);
            w[i] = b;
            m_s  = {m_s[NP-2:0], b};
        end
    endtask

    task automatic tick();
        logic [NTI-1:0] w;
        logic           inj;
        @(negedge clk);
        check("words_sent", words_sent, 64'(exp_words));
        check("errs_injected", {32'd0, errs_injected}, 64'(exp_errs));
        if (prev_stall && data_valid) check("stall_hold", {48'd0, data_out}, {48'd0, prev_data});
        if (data_valid && data_ready) begin
            gen_word(w);
            inj = (m_period != 0) && ((wi % m_period) == m_period - 1);
            check("word", {48'd0, data_out}, {48'd0, w ^ (inj ? NTI'(1) << m_lane : NTI'(0))});
            wi++;
            run_acc++;
            exp_words++;
            if (inj) exp_errs++;
        end
        prev_stall = data_valid && !data_ready;
        prev_data  = data_out;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [NP-1:0] seed, input logic [NP-1:0] eqn,
                             input int period, input int lane);
        prbs_seed      = seed;
        prbs_eqn       = eqn;
        err_inj_period = period;
        err_inj_lane   = lane[3:0];
        m_s            = (seed == '0) ? 1 : seed;
        m_eqn          = eqn;
        m_period       = period;
        m_lane         = lane;
        wi             = 0;
        run_acc        = 0;
        en             = 1'b1;
    endtask

    task automatic stop_run();
        en         = 1'b0;
        data_ready = 1'b0;
        tick();
        tick();
        check("idle_valid", {63'd0, data_valid}, 64'd0);
        check("idle_data", {48'd0, data_out}, 64'd0);
    endtask

    // mode 0: always ready, 1: random ready, 2: repeating 1,0,0,1
    task automatic run_words(input int n, input int mode);
        int cyc = 0;
        while (run_acc < n && cyc < n * 8 + 20) begin
            data_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) :
                         ((cyc % 4) == 0 || (cyc % 4) == 3);
            tick();
            cyc++;
        end
        if (run_acc < n) check("run_timeout", 64'(run_acc), 64'(n));
    endtask

    initial begin
        tick();
        tick();
        check("rst_data", {48'd0, data_out}, 64'd0);
        check("rst_valid", {63'd0, data_valid}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        start_run(32'h1, 32'h1, 0, 0);
        data_ready = 1'b1;
        tick();
        check("lat_load_valid", {63'd0, data_valid}, 64'd0);
        tick();
        check("lat_run_valid", {63'd0, data_valid}, 64'd0);
        tick();
        check("lat_first_valid", {63'd0, data_valid}, 64'd1);
        check("ones_word", {48'd0, data_out}, 64'hFFFF);
        run_words(20, 0);
        check("ones_word_late", {48'd0, data_out}, 64'hFFFF);
        stop_run();

        start_run(32'h1, 32'h2, 0, 0);
        data_ready = 1'b1;
        run_words(10, 0);
        check("alt_word", {48'd0, data_out}, 64'hAAAA);
        stop_run();

        start_run(32'h0, (32'h1 << 1) | (32'h1 << 20), 0, 0);
        run_words(1000, 1);
        stop_run();

        base_errs  = errs_injected;
        base_words = words_sent;
        start_run(32'h0, (32'h1 << 1) | (32'h1 << 20), 4, 3);
        run_words(100, 0);
        en         = 1'b0;
        data_ready = 1'b0;
        tick();
        tick();
        check("inj_errs_25", {32'd0, errs_injected - base_errs}, 64'd25);
        check("inj_words_100", words_sent - base_words, 64'd100);

        for (int r = 0; r < 3; r++) begin
            start_run($urandom, $urandom | 32'h8000_0000, $urandom_range(0, 7), $urandom_range(0, 15));
            run_words(150, 2);
            stop_run();
        end

        start_run(32'h1234_5678, 32'hA300_0001, 3, 7);
        data_ready = 1'b0;
        for (int c = 0; c < 10 && !data_valid; c++) tick();
        check("stall_valid_before_rst", {63'd0, data_valid}, 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, data_valid}, 64'd0);
        check("async_rst_data", {48'd0, data_out}, 64'd0);
        check("async_rst_words", words_sent, 64'd0);
        check("async_rst_errs", {32'd0, errs_injected}, 64'd0);
        en         = 1'b0;
        exp_words  = 0;
        exp_errs   = 0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_run(32'h1234_5678, 32'hA300_0001, 3, 7);
        run_words(30, 1);
        stop_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
